// File: rtl/cs_window_filter.sv
// Sliding-window approximate-average filter: circular sample buffer with running sum,
// per-sample iterative search for the entry closest to (not above) the mean.
module cs_window_filter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned WIN       = 9,
  parameter int unsigned OUT_SHIFT = 3,
  localparam int unsigned SUM_W    = DATA_W + $clog2(WIN) + 1,
  localparam int unsigned OUT_W    = SUM_W - OUT_SHIFT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mode,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data
);

  localparam int unsigned IDX_W = $clog2(WIN);
  localparam int unsigned CNT_W = $clog2(WIN + 1);
  localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(WIN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN - 1);

  typedef enum logic [1:0] {IDLE, AVG, SCAN, OUT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   win_q [WIN];
  logic [SUM_W-1:0]    sum_q;
  logic [IDX_W-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]    fill_q, fill_nxt;
  logic                mode_q;
  logic [DATA_W-1:0]   avg_q;
  logic [DATA_W-1:0]   rd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   best_q;
  logic [DATA_W:0]     best_diff_q;
  logic [OUT_W-1:0]    hold_q;
  logic [OUT_W-1:0]    result;
  logic                accept;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    accept    = (state_q == IDLE) && in_valid;
    fill_nxt  = (fill_q == WIN_C) ? fill_q : fill_q + 1'b1;
    case (state_q)
      IDLE: if (accept && fill_nxt == WIN_C) state_d = AVG;
      AVG:  state_d = SCAN;
      SCAN: if (cnt_q == WIN_C) state_d = OUT;
      OUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    if (mode_q) result = OUT_W'(avg_q);
    else        result = OUT_W'((sum_q + SUM_W'(WIN) * SUM_W'(best_q)) >> OUT_SHIFT);
  end

  assign out_data = (state_q == OUT) ? result : hold_q;

  // Scan reads the buffer into rd_q one cycle ahead of the compare, so SCAN
  // spends WIN+1 cycles: cnt 0 only fetches, cnt WIN only compares.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < WIN; i++) win_q[i] <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      mode_q      <= 1'b0;
      avg_q       <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      best_q      <= '0;
      best_diff_q <= '0;
      hold_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          win_q[wr_ptr_q] <= in_data;
          sum_q    <= sum_q - SUM_W'(win_q[wr_ptr_q]) + SUM_W'(in_data);
          wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
          fill_q   <= fill_nxt;
          mode_q   <= mode;
        end
        AVG: begin
          avg_q       <= DATA_W'(sum_q / SUM_W'(WIN));
          cnt_q       <= '0;
          best_q      <= '0;
          best_diff_q <= {1'b1, {DATA_W{1'b0}}};
        end
        SCAN: begin
          if (cnt_q < WIN_C) rd_q <= win_q[cnt_q[IDX_W-1:0]];
          if (cnt_q != '0 && rd_q <= avg_q && {1'b0, avg_q - rd_q} < best_diff_q) begin
            best_q      <= rd_q;
            best_diff_q <= {1'b0, avg_q - rd_q};
          end
          cnt_q <= cnt_q + 1'b1;
        end
        OUT: hold_q <= result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_window_filter.sv
// Directed bench for cs_window_filter with default parameters (9 taps, 8-bit, shift 3).
module tb_cs_window_filter;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned WIN       = 9;
  localparam int unsigned OUT_SHIFT = 3;
  localparam int unsigned OUT_W     = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              mode;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  cs_window_filter #(.DATA_W(DATA_W), .WIN(WIN), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .mode     (mode),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called #1 after the accept edge; expects the strobe WIN+2 edges later.
  task automatic wait_strobe(input string tag, input logic [OUT_W-1:0] exp, input bit chk_val);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < int'(WIN) + 8);
    check({tag, " latency"}, n, WIN + 2);
    if (chk_val) check({tag, " data"}, 32'(out_data), 32'(exp));
    @(posedge clk); #1;
    check({tag, " ready after"}, 32'(in_ready), 1);
  endtask

  // kind 0: warm-up, no strobe; 1: strobe, timing only; 2: strobe with value
  task automatic send(input logic [DATA_W-1:0] d, input logic m, input int kind,
                      input logic [OUT_W-1:0] exp, input string tag);
    int g = 0;
    while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
    in_valid = 1'b1; in_data = d; mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (kind == 0) check({tag, " warmup"}, {30'd0, in_ready, out_valid}, 32'd2);
    else           wait_strobe(tag, exp, kind == 2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_W-1:0] seq [9];
    int extra;
    int n;
    seq = '{8'd12, 8'd15, 8'd9, 8'd11, 8'd20, 8'd8, 8'd14, 8'd10, 8'd13};
    reset = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(in_ready), 1);
    check("reset valid", 32'(out_valid), 0);
    check("reset data", 32'(out_data), 0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) send(seq[i], 1'b0, 0, '0, "basic");
    send(seq[8], 1'b0, 2, 10'd27, "basic first");

    send(8'd30, 1'b0, 2, 10'd32, "slide");
    for (int i = 0; i < 8; i++) send(8'd0, 1'b0, 1, '0, "zeros");
    send(8'd0, 1'b0, 2, 10'd0, "zeros final");

    for (int i = 0; i < 8; i++) send(8'd0, 1'b0, 1, '0, "nomean");
    send(8'd100, 1'b0, 2, 10'd12, "nomean m0");
    for (int i = 0; i < 8; i++) send(8'd0, 1'b1, 1, '0, "nomean");
    send(8'd100, 1'b1, 2, 10'd11, "nomean m1");

    for (int i = 0; i < 8; i++) send(8'd255, 1'b0, 1, '0, "sat");
    send(8'd255, 1'b0, 2, 10'd573, "sat final");
    for (int i = 0; i < 8; i++) send(8'd5, 1'b0, 1, '0, "ties");
    send(8'd5, 1'b0, 2, 10'd11, "ties final");

    // Backpressure: a new sample is held on the bus while the filter is busy.
    in_valid = 1'b1; in_data = 8'd5; mode = 1'b0;
    @(posedge clk); #1;
    in_data = 8'd50;
    n = 0;
    repeat (3) begin @(posedge clk); #1; n++; end
    check("bp ready in scan", 32'(in_ready), 0);
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < int'(WIN) + 8);
    check("bp first latency", n, WIN + 2);
    check("bp first data", 32'(out_data), 11);
    check("bp ready in out", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("bp ready idle", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_strobe("bp second", 10'd16, 1'b1);
    extra = 0;
    repeat (WIN + 6) begin @(posedge clk); #1; if (out_valid) extra++; end
    check("bp single accept", extra, 0);

    // Reset while scanning.
    in_valid = 1'b1; in_data = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst valid", 32'(out_valid), 0);
    check("midrst data", 32'(out_data), 0);
    check("midrst ready", 32'(in_ready), 1);
    extra = 0;
    repeat (WIN + 4) begin @(posedge clk); #1; if (out_valid) extra++; end
    check("midrst no strobe", extra, 0);
    for (int i = 0; i < 8; i++) send(8'd7, 1'b0, 0, '0, "rewarm");
    send(8'd7, 1'b0, 2, 10'd15, "rewarm final");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
